bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
- Streaming FIFO controller that drives an external simple dual-port RAM (512x8, one write port, one read port with a registered 1-cycle read).
- Sits directly upstream of the RAM. It generates write enable, write address and write data, issues read addresses, and consumes the registered read data.
- Presents valid/ready streams on both sides.
- A 2-entry output buffer hides the RAM read latency, so one word per cycle is sustained in both directions.

Parameters:
- ADDR_W, 9, RAM address width; RAM depth DEPTH = 2**ADDR_W.
- DATA_W, 8, word width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all FIFO state
- in_data  in  DATA_W  producer word
- in_valid  in  1  producer has a word
- in_ready  out  1  controller accepts a word this cycle
- out_data  out  DATA_W  consumer word (registered)
- out_valid  out  1  out_data is valid (registered)
- out_ready  in  1  consumer takes the word this cycle
- level  out  ADDR_W+2  total words held: RAM + pending read + output buffer, 0..DEPTH+2
- ram_en_wr  out  1  RAM write enable
- ram_addr_wr  out  ADDR_W  RAM write address
- ram_data_wr  out  DATA_W  RAM write data (= in_data)
- ram_addr_rd  out  ADDR_W  RAM read address (= rd_ptr)
- ram_data_rd  in  DATA_W  RAM registered read data, valid the cycle after the address is presented

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous assert, active-low.
- Reset values:
  - wr_ptr = rd_ptr = 0, ram_level = 0, pend = 0, buf_cnt = 0
  - out_valid = 0, out_data = 0, running = 0, level = 0
  - in_ready = 0 and ram_en_wr = 0 while rst_n is low and for the first cycle after release (running sets on the first clk edge after release).
- Push:
  - in_ready = running & (ram_level != DEPTH) & ~flush.
  - push = in_valid & in_ready.
  - ram_en_wr = push; ram_addr_wr = wr_ptr; ram_data_wr = in_data.
  - On push, wr_ptr increments mod DEPTH and ram_level increments.
- Read issue:
  - ram_addr_rd = rd_ptr, combinational.
  - pop = out_valid & out_ready.
  - issue = (ram_level != 0) & (buf_cnt + pend - pop < 2) & ~flush.
  - On issue, rd_ptr increments mod DEPTH, ram_level decrements, and pend is set for the next cycle (pend <= issue).
- Return:
  - When pend = 1, ram_data_rd is written into the output buffer (head = out_data register, tail = skid register).
  - Head refill order: skid first, then returning RAM data.
  - buf_cnt <= buf_cnt + pend - pop.
  - out_valid = (buf_cnt != 0).
- Simultaneous push and issue in one cycle: ram_level is unchanged.
- Read/write address collision:
  - ram_addr_wr == ram_addr_rd only when ram_level is 0 (no issue) or DEPTH (no push).
  - A read therefore never targets a word written in the same cycle, so RAM read-during-write behaviour is irrelevant.
- Latency: a word pushed at edge E0 appears with out_valid high after edge E2 (2 cycles) when the FIFO was empty.
- Throughput: with continuous in_valid and out_ready, one word per cycle is sustained after the initial 2-cycle fill.
- Full: ram_level == DEPTH forces in_ready = 0. The output buffer may still hold 2 words; level = DEPTH+2 maximum.
- Empty: level == 0 gives out_valid = 0. out_data holds its last value.
- Wrap-around: both pointers wrap from DEPTH-1 to 0 with no bubble.
- level = ram_level + pend + buf_cnt, registered.
- Flush (synchronous):
  - A pop in the flush cycle completes normally; everything else in flight is discarded.
  - Next cycle: pointers, levels, pend, buf_cnt and out_valid are all 0.
  - in_ready = 0 during the flush cycle.
  - RAM contents are not cleared.
- Reset mid-operation: all in-flight and buffered data is discarded. RAM contents are retained but unreachable.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, the DEPTH derivation, and the level width constant.
- One natural sub-module: bram_fifo_outbuf, the 2-entry head/skid output buffer with valid/ready and a pend input.
- Pointer and level logic stays in the top.

Test Plan:
- Reset release with in_valid = 1 -> in_ready = 0 in the first cycle after release, 1 in the second; out_valid = 0; level = 0.
- Push 0xA5 into an empty FIFO at edge E0, out_ready = 1 -> out_valid high after E2, out_data = 0xA5, level returns to 0 after the pop.
- Stream 0x00..0xFF, then 0x00..0xFF again (512 words), with in_valid = out_ready = 1 continuously -> one word out per cycle after the 2-cycle fill; order intact across the pointer wrap at 511->0.
- out_ready = 0 while pushing 514 words -> in_ready falls after 514 accepted; level = 514; ram_en_wr never asserts when full. Then release out_ready -> all 514 words delivered in order.
- Random in_valid/out_ready (50% each) over 5000 words -> scoreboard matches, no loss or duplication, level always 0..514.
- Flush with 10 words held and out_valid = out_ready = 1 -> the head word transfers; next cycle level = 0 and out_valid = 0; a subsequent push of 0x3C emerges as the next word.

Source files
------------

// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants and width helpers for the BRAM-backed streaming FIFO controller.
// Defaults describe a 512x8 simple dual-port RAM behind a 2-entry output buffer.
package bram_fifo_ctrl_pkg;

    localparam int FIFO_ADDR_W    = 9;
    localparam int FIFO_DATA_W    = 8;
    localparam int OUTBUF_ENTRIES = 2;

    function automatic int depth_of(input int addr_w);
        return 2 ** addr_w;
    endfunction

    // Level counts RAM words plus one pending read plus the output buffer: 0..DEPTH+2.
    function automatic int level_width(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Stream, status and RAM-port signals of the FIFO controller bundled into one interface.
// The slave modport is the controller's view; master is the surrounding system.
interface bram_fifo_ctrl_if
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W
);

    localparam int LEVEL_W = level_width(ADDR_W);

    logic               flush;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic [LEVEL_W-1:0] level;
    logic               ram_en_wr;
    logic [ADDR_W-1:0]  ram_addr_wr;
    logic [DATA_W-1:0]  ram_data_wr;
    logic [ADDR_W-1:0]  ram_addr_rd;
    logic [DATA_W-1:0]  ram_data_rd;

    modport slave (
        input  flush, in_data, in_valid, out_ready, ram_data_rd,
        output in_ready, out_data, out_valid, level,
               ram_en_wr, ram_addr_wr, ram_data_wr, ram_addr_rd
    );

    modport master (
        output flush, in_data, in_valid, out_ready, ram_data_rd,
        input  in_ready, out_data, out_valid, level,
               ram_en_wr, ram_addr_wr, ram_data_wr, ram_addr_rd
    );

endinterface

// File: rtl/bram_fifo_ctrl_outbuf.sv
// Two-entry head/skid output buffer absorbing the one-cycle registered RAM read latency.
// out_data is the head register; the skid register only fills when the head is held.
module bram_fifo_outbuf
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              pend,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        buf_cnt,
    output logic              pop
);

    logic [DATA_W-1:0] skid;
    logic [1:0]        cnt_next;
    logic              head_from_skid;
    logic              head_from_ram;
    logic              skid_from_ram;

    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid & out_ready;

    // Head refills from skid before taking returning RAM data, preserving order.
    always_comb begin
        head_from_skid = 1'b0;
        head_from_ram  = 1'b0;
        skid_from_ram  = 1'b0;
        cnt_next       = buf_cnt + {1'b0, pend} - {1'b0, pop};
        if (pop) begin
            if (buf_cnt == 2'd2) begin
                head_from_skid = 1'b1;
                skid_from_ram  = pend;
            end else begin
                head_from_ram  = pend;
            end
        end else begin
            if (buf_cnt == 2'd0) begin
                head_from_ram = pend;
            end else if (buf_cnt == 2'd1) begin
                skid_from_ram = pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt  <= 2'd0;
            out_data <= '0;
        end else if (flush) begin
            buf_cnt  <= 2'd0;
        end else begin
            buf_cnt <= cnt_next;
            if (head_from_skid) begin
                out_data <= skid;
            end else if (head_from_ram) begin
                out_data <= ram_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (skid_from_ram && !flush) begin
            skid <= ram_data;
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller driving an external simple dual-port RAM with registered read.
// Owns the write/read pointers and occupancy; the output buffer hides the read latency.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W
) (
    input logic            clk,
    input logic            rst_n,
    bram_fifo_ctrl_if.slave bus
);

    localparam int LEVEL_W = level_width(ADDR_W);
    localparam logic [ADDR_W:0] RAM_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [2:0]      BUF_LIMIT = 3'(OUTBUF_ENTRIES);

    logic               running;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    ram_level;
    logic [ADDR_W:0]    ram_level_next;
    logic               pend;
    logic [1:0]         buf_cnt;
    logic               pop;
    logic               push;
    logic               issue;
    logic               in_ready;
    logic [2:0]         buf_occ;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_next;

    assign in_ready = running & (ram_level != RAM_FULL) & ~bus.flush;
    assign push     = bus.in_valid & in_ready;

    // Occupancy the buffer will have once the pending read lands and any pop retires.
    assign buf_occ = {1'b0, buf_cnt} + {2'b00, pend} - {2'b00, pop};
    assign issue   = (ram_level != '0) & (buf_occ < BUF_LIMIT) & ~bus.flush;

    always_comb begin
        ram_level_next = ram_level;
        if (push && !issue) begin
            ram_level_next = ram_level + 1'b1;
        end else if (!push && issue) begin
            ram_level_next = ram_level - 1'b1;
        end
    end

    // Reads and returns only move words internally; only push and pop change the total.
    always_comb begin
        level_next = level_q;
        if (push && !pop) begin
            level_next = level_q + 1'b1;
        end else if (!push && pop) begin
            level_next = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_level <= '0;
            pend      <= 1'b0;
            level_q   <= '0;
        end else begin
            running <= 1'b1;
            if (bus.flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                ram_level <= '0;
                pend      <= 1'b0;
                level_q   <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (issue) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                ram_level <= ram_level_next;
                pend      <= issue;
                level_q   <= level_next;
            end
        end
    end

    bram_fifo_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .pend      (pend),
        .ram_data  (bus.ram_data_rd),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .buf_cnt   (buf_cnt),
        .pop       (pop)
    );

    assign bus.in_ready    = in_ready;
    assign bus.ram_en_wr   = push;
    assign bus.ram_addr_wr = wr_ptr;
    assign bus.ram_data_wr = bus.in_data;
    assign bus.ram_addr_rd = rd_ptr;
    assign bus.level       = level_q;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural 512x8 registered-read RAM.
module tb_bram_fifo_ctrl;

    localparam int AW     = 9;
    localparam int DW     = 8;
    localparam int DEPTH  = 512;
    localparam int MAXLVL = DEPTH + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bram_fifo_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.ram_en_wr) mem[bus.ram_addr_wr] <= bus.ram_data_wr;
        bus.ram_data_rd <= mem[bus.ram_addr_rd];
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] tb_wp = '0;

    logic          s_pushed, s_popped, s_wen, s_in_ready, s_out_valid;
    logic [DW-1:0] s_od, s_wdata;
    logic [AW-1:0] s_waddr, s_exp_waddr;
    int            s_lvl, s_sz;

    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        s_in_ready  = bus.in_ready;
        s_out_valid = bus.out_valid;
        s_pushed    = bus.in_valid & bus.in_ready;
        s_popped    = bus.out_valid & bus.out_ready;
        s_od        = bus.out_data;
        s_wen       = bus.ram_en_wr;
        s_waddr     = bus.ram_addr_wr;
        s_wdata     = bus.ram_data_wr;
        s_lvl       = int'(bus.level);
        s_sz        = exp_q.size();
        s_exp_waddr = tb_wp;
        if (s_pushed) begin
            exp_q.push_back(d);
            tb_wp = tb_wp + 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_data = 8'h11; bus.out_ready = 1'b0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.ram_en_wr !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b/%b required 0/0", bus.in_ready, bus.ram_en_wr);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== '0 || bus.out_data !== '0) begin
            n_fail++; $display("FAIL reset_outputs: valid %b level %0d data %0h required 0/0/0", bus.out_valid, bus.level, bus.out_data);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL release_first_cycle: in_ready %b required 0", bus.in_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_second_cycle: in_ready %b required 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
            n_fail++; $display("FAIL release_empty: valid %b level %0d required 0/0", bus.out_valid, bus.level);
        end
        bus.in_valid = 1'b0;
        exp_q.delete();
        tb_wp = '0;
    endtask

    task automatic test_single();
        logic [DW-1:0] e;
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        n_checks++;
        if (s_pushed !== 1'b1) begin
            n_fail++; $display("FAIL single_push: accepted %b required 1", s_pushed);
        end
        for (int i = 1; i <= 2; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (s_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL single_latency: out_valid %b after %0d edges required 0", s_out_valid, i);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (s_popped !== 1'b1) begin
            n_fail++; $display("FAIL single_valid: out_valid %b after 2 edges required 1", s_out_valid);
        end else begin
            e = exp_q.pop_front();
            if (s_od !== e) begin
                n_fail++; $display("FAIL single_data: got %0h required %0h", s_od, e);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (s_lvl != 0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drained: level %0d valid %b required 0/0", s_lvl, s_out_valid);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] e;
        for (int i = 0; i < 520; i++) begin
            step(i < 512, 8'(i), 1'b1, 1'b0);
            if (i < 512) begin
                n_checks++;
                if (s_pushed !== 1'b1) begin
                    n_fail++; $display("FAIL stream_accept: word %0d in_ready %b required 1", i, s_in_ready);
                end
            end
            if (i >= 3 && i <= 514) begin
                n_checks++;
                if (s_popped !== 1'b1) begin
                    n_fail++; $display("FAIL stream_rate: cycle %0d out_valid %b required 1", i, s_out_valid);
                end
            end
            if (s_popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: popped %0h with nothing required", s_od);
                end else begin
                    e = exp_q.pop_front();
                    if (s_od !== e) begin
                        n_fail++; $display("FAIL stream_data: cycle %0d got %0h required %0h", i, s_od, e);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_lost: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] e;
        int accepted = 0;
        int guard = 0;
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 8'(i) ^ 8'h5A, 1'b0, 1'b0);
            if (s_pushed) accepted++;
            n_checks++;
            if (s_wen !== s_pushed) begin
                n_fail++; $display("FAIL full_wen: cycle %0d ram_en_wr %b required %b", i, s_wen, s_pushed);
            end
        end
        n_checks++;
        if (accepted != MAXLVL) begin
            n_fail++; $display("FAIL full_count: accepted %0d required %0d", accepted, MAXLVL);
        end
        n_checks++;
        if (s_lvl != MAXLVL || s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_level: level %0d in_ready %b required %0d/0", s_lvl, s_in_ready, MAXLVL);
        end
        while (exp_q.size() != 0 && guard < 2000) begin
            guard++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (s_popped) begin
                n_checks++;
                e = exp_q.pop_front();
                if (s_od !== e) begin
                    n_fail++; $display("FAIL full_drain_data: got %0h required %0h", s_od, e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL full_drain_timeout: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e, d;
        int accepted = 0;
        int guard = 0;
        while ((accepted < 5000 || exp_q.size() != 0) && guard < 40000) begin
            guard++;
            d = 8'($urandom_range(0, 255));
            step((accepted < 5000) ? 1'($urandom_range(0, 1)) : 1'b0, d, 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (s_lvl != s_sz || s_lvl > MAXLVL) begin
                n_fail++; $display("FAIL random_level: got %0d required %0d", s_lvl, s_sz);
            end
            if (s_pushed) begin
                accepted++;
                n_checks++;
                if (s_wen !== 1'b1 || s_waddr !== s_exp_waddr || s_wdata !== d) begin
                    n_fail++; $display("FAIL random_write: en %b addr %0d data %0h required 1/%0d/%0h", s_wen, s_waddr, s_wdata, s_exp_waddr, d);
                end
            end
            if (s_popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL random_extra: popped %0h with nothing required", s_od);
                end else begin
                    e = exp_q.pop_front();
                    if (s_od !== e) begin
                        n_fail++; $display("FAIL random_data: got %0h required %0h", s_od, e);
                    end
                end
            end
        end
        n_checks++;
        if (accepted != 5000 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_timeout: accepted %0d outstanding %0d required 5000/0", accepted, exp_q.size());
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] e;
        int guard = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (s_lvl != 10) begin
            n_fail++; $display("FAIL flush_prefill: level %0d required 10", s_lvl);
        end
        step(1'b1, 8'h77, 1'b1, 1'b1);
        n_checks++;
        if (s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b required 0", s_in_ready);
        end
        n_checks++;
        if (s_popped !== 1'b1) begin
            n_fail++; $display("FAIL flush_pop: out_valid %b required 1", s_out_valid);
        end else begin
            e = exp_q.pop_front();
            if (s_od !== e) begin
                n_fail++; $display("FAIL flush_head: got %0h required %0h", s_od, e);
            end
        end
        exp_q.delete();
        tb_wp = '0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (s_lvl != 0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_cleared: level %0d valid %b required 0/0", s_lvl, s_out_valid);
        end
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        n_checks++;
        if (s_pushed !== 1'b1 || s_waddr !== '0) begin
            n_fail++; $display("FAIL flush_repush: accepted %b addr %0d required 1/0", s_pushed, s_waddr);
        end
        while (exp_q.size() != 0 && guard < 20) begin
            guard++;
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (s_popped) begin
                n_checks++;
                e = exp_q.pop_front();
                if (s_od !== e) begin
                    n_fail++; $display("FAIL flush_next_word: got %0h required %0h", s_od, e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL flush_timeout: %0d words outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_random();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
